command_decoder: RTL
====================

COMMAND_DECODER -- requirements
Module: command_decoder

Interface
REQ-001 The block SHALL have parameter COMMAND_BUFFER_SIZE, default 64, giving the number of command words in the fetcher buffer.
REQ-002 The block SHALL have parameter COMMAND_DEPTH, default 64, giving the command word width in bits.
REQ-003 aClock  in  1  sole clock, all state on rising edge.
REQ-004 aReset  in  1  asynchronous, active-low reset.
REQ-005 aStart  in  1  begin decoding at index 0; honoured only in IDLE or ERROR with aFetcherReady high.
REQ-006 aFetcherReady  in  1  command buffer filled and readable.
REQ-007 anOutCommandIndex  out  $clog2(COMMAND_BUFFER_SIZE)  buffer read index.
REQ-008 anOutCommandRead  out  1  buffer read enable; data returns exactly 1 cycle later.
REQ-009 aCommandData  in  COMMAND_DEPTH  buffer read data.
REQ-010 anOutRegWrite / anOutRegAddr / anOutRegData  out  1/16/32  register-write pulse and fields.
REQ-011 anOutStreamValid / anOutStreamData  out  1/COMMAND_DEPTH, and aStreamReady  in  1: valid/ready downstream stream.
REQ-012 anOutBusy, anOutDone, anOutError  out  1 each; anOutErrorCode  out  2.

Function
REQ-013 Word format: [63:56] opcode, [55:0] payload; opcodes NOP=0x00, END=0x01, SET_REG=0x02 ([47:32] addr, [31:0] data), DISPATCH=0x03 ([15:0] count N), JUMP=0x04 ([5:0] target index).
REQ-014 States: IDLE, READ, DECODE, STREAM_READ, STREAM_WAIT, DONE, ERROR.
REQ-015 IDLE/ERROR + aStart + aFetcherReady -> READ with index 0, error flag and code cleared; aStart without aFetcherReady is ignored.
REQ-016 READ: assert anOutCommandRead for one cycle at current index -> DECODE.
REQ-017 DECODE samples aCommandData. NOP: index+1 -> READ. SET_REG: one-cycle anOutRegWrite with fields, index+1 -> READ. JUMP: index=target -> READ. END -> DONE. Other opcode -> ERROR, code 1.
REQ-018 DISPATCH with N=0 behaves as NOP; with index+N > COMMAND_BUFFER_SIZE-1 -> ERROR, code 2, no stream beat emitted.
REQ-019 DISPATCH with valid N: for each of words index+1..index+N, STREAM_READ issues the read, then STREAM_WAIT holds anOutStreamValid high with stable data until aStreamReady; after beat N, index=index+N+1 -> READ.
REQ-020 Minimum two cycles per stream beat; anOutStreamValid never drops before acceptance; aStreamReady with valid low is ignored.
REQ-021 Advancing index beyond COMMAND_BUFFER_SIZE-1 (NOP/SET_REG at last index) -> ERROR, code 2; the index never wraps.
REQ-022 DONE: anOutDone high one cycle -> IDLE.
REQ-023 anOutBusy high in READ, DECODE, STREAM_READ, STREAM_WAIT.
REQ-024 ERROR: anOutError and anOutErrorCode held until accepted aStart or reset; code 0 = none.
REQ-025 aStart while busy SHALL be ignored.

Reset
REQ-026 aReset low SHALL immediately force IDLE, index 0, and all outputs 0, including mid-stream; no partial beat after release.
REQ-027 The first action after reset release SHALL require a fresh aStart.

Structure
REQ-028 Opcode enum, field bit positions, error-code constants and COMMAND_DEPTH SHALL live in the shared Defines package, shared with the command fetcher.
REQ-029 The block SHALL be a single module with no sub-module; the fetcher's buffer read port connects directly.

Verification
REQ-030 Buffer {SET_REG addr 0x0010 data 0xDEADBEEF, END}, aStart -> one anOutRegWrite with those fields, then anOutDone pulse, error 0.
REQ-031 {DISPATCH N=3, words A,B,C, END}, aStreamReady low 5 cycles, then high -> beats A,B,C in order, valid held stable while stalled, then done.
REQ-032 Opcode 0x7F at index 0 -> ERROR code 1, no reg/stream activity; second aStart clears the error.
REQ-033 DISPATCH N=10 at index 60 (size 64) -> ERROR code 2, zero stream beats.
REQ-034 JUMP target 5 at index 0, END at index 5 -> reads index 0, then 5, then done; aReset low during STREAM_WAIT -> all outputs 0 within the same cycle.

Source files
------------

// File: rtl/command_decoder_pkg.sv
// Shared command-word definitions used by the command decoder and the command fetcher.
// Holds opcode values, field positions, error codes and the default command word width.
package command_decoder_pkg;

  localparam int COMMAND_DEPTH = 64;

  // Command word field positions
  localparam int OPCODE_MSB   = 63;
  localparam int OPCODE_LSB   = 56;
  localparam int REG_ADDR_MSB = 47;
  localparam int REG_ADDR_LSB = 32;
  localparam int REG_DATA_MSB = 31;
  localparam int REG_DATA_LSB = 0;
  localparam int COUNT_MSB    = 15;
  localparam int COUNT_LSB    = 0;
  localparam int TARGET_MSB   = 5;
  localparam int TARGET_LSB   = 0;

  typedef enum logic [7:0] {
    opNop      = 8'h00,
    opEnd      = 8'h01,
    opSetReg   = 8'h02,
    opDispatch = 8'h03,
    opJump     = 8'h04
  } opcode_t;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_OPCODE = 2'd1;
  localparam logic [1:0] ERR_RANGE  = 2'd2;

  typedef enum logic [2:0] {
    stIdle,
    stRead,
    stDecode,
    stStreamRead,
    stStreamWait,
    stDone,
    stError
  } decoderState_t;

endpackage

// File: rtl/command_decoder.sv
// Walks the command buffer from index 0, issuing register writes and streaming DISPATCH payloads;
// two cycles per command word, stream beats held until aStreamReady, no read issued while stalled.
module command_decoder #(
  parameter int COMMAND_BUFFER_SIZE = 64,
  parameter int COMMAND_DEPTH = command_decoder_pkg::COMMAND_DEPTH,
  localparam int INDEX_WIDTH = $clog2(COMMAND_BUFFER_SIZE)
) (
  input  logic                     aClock,
  input  logic                     aReset,
  input  logic                     aStart,
  input  logic                     aFetcherReady,
  output logic [INDEX_WIDTH-1:0]   anOutCommandIndex,
  output logic                     anOutCommandRead,
  input  logic [COMMAND_DEPTH-1:0] aCommandData,
  output logic                     anOutRegWrite,
  output logic [15:0]              anOutRegAddr,
  output logic [31:0]              anOutRegData,
  output logic                     anOutStreamValid,
  output logic [COMMAND_DEPTH-1:0] anOutStreamData,
  input  logic                     aStreamReady,
  output logic                     anOutBusy,
  output logic                     anOutDone,
  output logic                     anOutError,
  output logic [1:0]               anOutErrorCode
);

  import command_decoder_pkg::*;

  decoderState_t            state, stateNext;
  logic [INDEX_WIDTH-1:0]   index, indexNext;
  logic [15:0]              remaining, remainingNext;
  logic [COMMAND_DEPTH-1:0] heldData, heldDataNext;
  logic                     firstWait, firstWaitNext;
  logic [1:0]               errorCode, errorCodeNext;
  logic                     regWrite, regWriteNext;
  logic [15:0]              regAddr, regAddrNext;
  logic [31:0]              regData, regDataNext;
  logic                     advance;

  logic [7:0]  opcode;
  logic [15:0] dispatchCount;
  logic [31:0] dispatchReach;
  logic [31:0] jumpTarget;
  logic        atLastIndex;

  assign opcode        = aCommandData[OPCODE_MSB:OPCODE_LSB];
  assign dispatchCount = aCommandData[COUNT_MSB:COUNT_LSB];
  assign dispatchReach = 32'(index) + 32'(dispatchCount);
  assign jumpTarget    = 32'(aCommandData[TARGET_MSB:TARGET_LSB]);
  assign atLastIndex   = (index == INDEX_WIDTH'(COMMAND_BUFFER_SIZE - 1));

  always_ff @(posedge aClock or negedge aReset) begin
    if (!aReset) begin
      state     <= stIdle;
      index     <= '0;
      remaining <= '0;
      heldData  <= '0;
      firstWait <= 1'b0;
      errorCode <= ERR_NONE;
      regWrite  <= 1'b0;
      regAddr   <= '0;
      regData   <= '0;
    end else begin
      state     <= stateNext;
      index     <= indexNext;
      remaining <= remainingNext;
      heldData  <= heldDataNext;
      firstWait <= firstWaitNext;
      errorCode <= errorCodeNext;
      regWrite  <= regWriteNext;
      regAddr   <= regAddrNext;
      regData   <= regDataNext;
    end
  end

  always_comb begin
    stateNext     = state;
    indexNext     = index;
    remainingNext = remaining;
    heldDataNext  = heldData;
    firstWaitNext = 1'b0;
    errorCodeNext = errorCode;
    regWriteNext  = 1'b0;
    regAddrNext   = regAddr;
    regDataNext   = regData;
    advance       = 1'b0;

    case (state)
      stIdle, stError: begin
        if (aStart && aFetcherReady) begin
          stateNext     = stRead;
          indexNext     = '0;
          errorCodeNext = ERR_NONE;
        end
      end
      stRead: stateNext = stDecode;
      stDecode: begin
        case (opcode)
          opNop: advance = 1'b1;
          opSetReg: begin
            regWriteNext = 1'b1;
            regAddrNext  = aCommandData[REG_ADDR_MSB:REG_ADDR_LSB];
            regDataNext  = aCommandData[REG_DATA_MSB:REG_DATA_LSB];
            advance      = 1'b1;
          end
          opJump: begin
            if (jumpTarget > 32'(COMMAND_BUFFER_SIZE - 1)) begin
              stateNext     = stError;
              errorCodeNext = ERR_RANGE;
            end else begin
              indexNext = INDEX_WIDTH'(jumpTarget);
              stateNext = stRead;
            end
          end
          opEnd: stateNext = stDone;
          opDispatch: begin
            if (dispatchCount == '0) begin
              advance = 1'b1;
            end else if (dispatchReach > 32'(COMMAND_BUFFER_SIZE - 1)) begin
              stateNext     = stError;
              errorCodeNext = ERR_RANGE;
            end else begin
              remainingNext = dispatchCount;
              indexNext     = index + INDEX_WIDTH'(1);
              stateNext     = stStreamRead;
            end
          end
          default: begin
            stateNext     = stError;
            errorCodeNext = ERR_OPCODE;
          end
        endcase
      end
      stStreamRead: begin
        stateNext     = stStreamWait;
        firstWaitNext = 1'b1;
      end
      stStreamWait: begin
        // Read data is only guaranteed on the first wait cycle; keep a copy for long stalls.
        if (firstWait) heldDataNext = aCommandData;
        if (aStreamReady) begin
          if (remaining == 16'd1) begin
            advance = 1'b1;
          end else begin
            remainingNext = remaining - 16'd1;
            indexNext     = index + INDEX_WIDTH'(1);
            stateNext     = stStreamRead;
          end
        end else begin
          firstWaitNext = 1'b0;
        end
      end
      stDone: stateNext = stIdle;
      default: stateNext = stIdle;
    endcase

    // Stepping past the last buffer word is an error rather than a wrap to 0.
    if (advance) begin
      if (atLastIndex) begin
        stateNext     = stError;
        errorCodeNext = ERR_RANGE;
      end else begin
        indexNext = index + INDEX_WIDTH'(1);
        stateNext = stRead;
      end
    end
  end

  assign anOutCommandIndex = index;
  assign anOutCommandRead  = (state == stRead) || (state == stStreamRead);
  assign anOutRegWrite     = regWrite;
  assign anOutRegAddr      = regAddr;
  assign anOutRegData      = regData;
  assign anOutStreamValid  = (state == stStreamWait);
  assign anOutStreamData   = (state != stStreamWait) ? '0 : (firstWait ? aCommandData : heldData);
  assign anOutBusy         = (state == stRead) || (state == stDecode) ||
                             (state == stStreamRead) || (state == stStreamWait);
  assign anOutDone         = (state == stDone);
  assign anOutError        = (state == stError);
  assign anOutErrorCode    = errorCode;

endmodule
